// File: rtl/dc_pwm_drive.sv
// Soft-start PWM driver for the MA H-bridge pair: ramped PWM on one leg, other leg low,
// coast dead-time before any reversal. Define DC_PWM_SOFTSTART_EN to build the RAMP/STOP ramps.
module dc_pwm_drive #(
    parameter int PERIOD   = 1000,
    parameter int DW       = 10,
    parameter int DUTY_MAX = 800,
    parameter int RAMP_INC = 8,
    parameter int DEAD_CYC = 50000
) (
    input  logic          sclk,
    input  logic          s_rst,
    input  logic          enable,
    input  logic          direct,
    output logic [1:0]    MA,
    output logic          busy,
    output logic [DW-1:0] duty
);

    localparam int CW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    localparam logic [DW-1:0] PCNT_LAST = DW'(PERIOD - 1);
    localparam logic [DW-1:0] DUTY_RUN  = DW'(DUTY_MAX);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_DEAD = 3'd4;
`ifdef DC_PWM_SOFTSTART_EN
    localparam logic [2:0] ST_RAMP = 3'd1;
    localparam logic [2:0] ST_STOP = 3'd3;

    localparam logic [DW:0] INC_W = (DW + 1)'(RAMP_INC);
    localparam logic [DW:0] MAX_W = (DW + 1)'(DUTY_MAX);
`endif

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [DW-1:0] pcnt;
    logic [DW-1:0] duty_next;
    logic          dir_q;
    logic          dir_next;
    logic [CW-1:0] dead_cnt;
    logic [CW-1:0] dead_next;
    logic          pend;
    logic          pwm_on;
    logic          stop_req;
    logic          drive;
    logic [1:0]    ma_next;

    assign pend     = (pcnt == PCNT_LAST);
    assign pwm_on   = (pcnt < duty);
    assign stop_req = !enable || (direct != dir_q);

`ifdef DC_PWM_SOFTSTART_EN
    // One extra bit so the step can overshoot or borrow before saturating.
    logic [DW:0]   up_sum;
    logic [DW:0]   dn_diff;
    logic [DW-1:0] ramp_up;
    logic [DW-1:0] ramp_dn;

    assign up_sum  = {1'b0, duty} + INC_W;
    assign dn_diff = {1'b0, duty} - INC_W;
    assign ramp_up = (up_sum >= MAX_W) ? DUTY_RUN : up_sum[DW-1:0];
    assign ramp_dn = dn_diff[DW] ? '0 : dn_diff[DW-1:0];
`endif

    always_comb begin
        state_next = state;
        duty_next  = duty;
        dir_next   = dir_q;
        dead_next  = dead_cnt;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    dir_next = direct;
`ifdef DC_PWM_SOFTSTART_EN
                    state_next = ST_RAMP;
`else
                    state_next = ST_RUN;
                    duty_next  = DUTY_RUN;
`endif
                end
            end
`ifdef DC_PWM_SOFTSTART_EN
            ST_RAMP: begin
                if (stop_req) begin
                    state_next = ST_STOP;
                end else if (pend) begin
                    duty_next = ramp_up;
                    if (ramp_up == DUTY_RUN) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_STOP: begin
                if (pend) begin
                    duty_next = ramp_dn;
                    if (ramp_dn == '0) begin
                        state_next = ST_DEAD;
                    end
                end
            end
`endif
            ST_RUN: begin
                if (stop_req) begin
`ifdef DC_PWM_SOFTSTART_EN
                    state_next = ST_STOP;
`else
                    state_next = ST_DEAD;
                    duty_next  = '0;
`endif
                end
            end
            ST_DEAD: begin
                // Requests are deliberately ignored until the full coast time has elapsed.
                if (dead_cnt == DEAD_LAST) begin
                    dead_next  = '0;
                    state_next = ST_IDLE;
                end else begin
                    dead_next = dead_cnt + CW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                duty_next  = '0;
                dead_next  = '0;
            end
        endcase
    end

    // Only one leg is ever selected, so MA can never be 2'b11.
    assign drive   = (state != ST_IDLE) && (state != ST_DEAD);
    assign ma_next = !drive ? 2'b00 : (dir_q ? {pwm_on, 1'b0} : {1'b0, pwm_on});

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            pcnt <= '0;
        end else if (pend) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + DW'(1);
        end
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state    <= ST_IDLE;
            duty     <= '0;
            dir_q    <= 1'b0;
            dead_cnt <= '0;
            MA       <= 2'b00;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            duty     <= duty_next;
            dir_q    <= dir_next;
            dead_cnt <= dead_next;
            MA       <= ma_next;
            busy     <= (state != ST_IDLE);
        end
    end

endmodule
